// File: rtl/link_ddr_pkg.sv
// Shared widths, assembler state type and piece slice helpers for the DDR link
// downstream receive path.
package link_ddr_pkg;

    localparam int unsigned CHANNEL_WIDTH = 8;
    localparam int unsigned NUM_CHANNELS  = 2;
    localparam int unsigned PIECES        = 2;

    // One channel carries a posedge half and a negedge half per io cycle.
    localparam int unsigned LANE_WIDTH    = 2 * CHANNEL_WIDTH;
    localparam int unsigned PIECE_WIDTH   = LANE_WIDTH * NUM_CHANNELS;
    localparam int unsigned CORE_WIDTH    = PIECE_WIDTH * PIECES;

    // Piece placement inside a core word.
    localparam int unsigned PIECE0_LSB    = 0;
    localparam int unsigned PIECE1_LSB    = PIECE_WIDTH;

    // Half placement inside one channel lane.
    localparam int unsigned POS_HALF_LSB  = 0;
    localparam int unsigned NEG_HALF_LSB  = CHANNEL_WIDTH;

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } asm_state_e;

    // LSB of channel ch within an io piece.
    function automatic int unsigned chan_lsb(input int unsigned ch);
        return ch * LANE_WIDTH;
    endfunction

endpackage

// File: rtl/link_ddr_rx_fifo.sv
// Synchronous FIFO for reassembled core words. Pointers carry one extra wrap
// bit; a write while full is accepted only if a read happens the same cycle.
module link_ddr_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic [WIDTH-1:0] wdata,
    input  logic             deq,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             rd_fire;
    logic             wr_fire;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_fire = deq & ~empty;
    assign wr_fire = enq & (~full | rd_fire);
    assign head    = mem[rd_ptr_q[AW-1:0]];

    // Pointer advance on accepted reads and writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_fire) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/link_ddr_downstream_rx.sv
// DDR link downstream receiver: pairs two io pieces into one core word,
// buffers words in a FIFO and returns credit as toggled token bits.
// Optional macro LINK_DS_RX_ERR_EN enables the sticky err_o detection.
module link_ddr_downstream_rx #(
    parameter int unsigned CHANNEL_WIDTH      = link_ddr_pkg::CHANNEL_WIDTH,
    parameter int unsigned NUM_CHANNELS       = link_ddr_pkg::NUM_CHANNELS,
    parameter int unsigned PIECES             = link_ddr_pkg::PIECES,
    parameter int unsigned FIFO_DEPTH         = 8,
    parameter int unsigned LG_CREDIT_TO_TOKEN = 3
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_CHANNELS-1:0]                       io_valid_i,
    input  logic [CHANNEL_WIDTH*2*NUM_CHANNELS-1:0]        io_data_i,
    output logic                                          core_valid_o,
    output logic [CHANNEL_WIDTH*2*NUM_CHANNELS*PIECES-1:0] core_data_o,
    input  logic                                          core_yumi_i,
    output logic [NUM_CHANNELS-1:0]                       token_o,
    output logic                                          err_o
);

    import link_ddr_pkg::*;

    localparam int unsigned PIECE_W = CHANNEL_WIDTH * 2 * NUM_CHANNELS;
    localparam int unsigned CORE_W  = PIECE_W * PIECES;
    localparam logic [LG_CREDIT_TO_TOKEN-1:0] CREDIT_ONE = LG_CREDIT_TO_TOKEN'(1);

    asm_state_e                  state_q, state_d;
    logic [PIECE_W-1:0]          low_q;
    logic                        accept;
    logic                        low_load;
    logic                        asm_enq;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        deq_fire;
    logic [LG_CREDIT_TO_TOKEN-1:0] credit_q;
    logic [NUM_CHANNELS-1:0]     token_q;

    // A piece counts only when every channel reports valid.
    assign accept = &io_valid_i;

    // Assembler state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= P0;
        else     state_q <= state_d;
    end

    // Assembler next state: P0 latches the low piece, P1 completes the word.
    always_comb begin
        state_d  = state_q;
        low_load = 1'b0;
        asm_enq  = 1'b0;
        unique case (state_q)
            P0: if (accept) begin
                    low_load = 1'b1;
                    state_d  = P1;
                end
            P1: if (accept) begin
                    asm_enq  = 1'b1;
                    state_d  = P0;
                end
            default: state_d = P0;
        endcase
    end

    // Low piece holding register.
    always_ff @(posedge clk) begin
        if (rst)           low_q <= '0;
        else if (low_load) low_q <= io_data_i;
    end

    link_ddr_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CORE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .enq   (asm_enq),
        .wdata ({io_data_i, low_q}),
        .deq   (core_yumi_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (core_data_o)
    );

    assign core_valid_o = ~fifo_empty;
    assign deq_fire     = core_yumi_i & ~fifo_empty;

    // Credit counter; token bits flip together when the counter wraps to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= '0;
            token_q  <= '0;
        end else if (deq_fire) begin
            credit_q <= credit_q + CREDIT_ONE;
            if (credit_q == '1) token_q <= ~token_q;
        end
    end

    assign token_o = token_q;

`ifdef LINK_DS_RX_ERR_EN
    logic mismatch;
    logic overflow;
    logic err_q;

    assign mismatch = (|io_valid_i) & ~accept;
    assign overflow = asm_enq & fifo_full & ~deq_fire;

    // Sticky protocol error: partial valids or a word dropped on a full FIFO.
    always_ff @(posedge clk) begin
        if (rst)                      err_q <= 1'b0;
        else if (mismatch | overflow) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    // Full flag only feeds error detection, which is compiled out here.
    logic full_unused;
    assign full_unused = fifo_full;
    assign err_o       = 1'b0;
`endif

endmodule
